// File: rtl/mainfsm_if.sv
// Handshake bundle between the multicycle controller FSM and the datapath/decoder side.
// The slave modport is the FSM; the master modport is whoever supplies the instruction fields.
interface mainfsm_if;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       IRWrite;
  logic       AdrSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic       NextPC;
  logic       RegW;
  logic       MemW;
  logic       Branch;
  logic       ALUOp;
  logic       Illegal;
  logic [3:0] State;

  modport master (
    output Op, Funct,
    input  IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
    input  NextPC, RegW, MemW, Branch, ALUOp, Illegal, State
  );

  modport slave (
    input  Op, Funct,
    output IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
    output NextPC, RegW, MemW, Branch, ALUOp, Illegal, State
  );
endinterface

// File: rtl/mainfsm.sv
// Moore control FSM of the multicycle ARM core: sequences fetch/decode/execute/memory/writeback.
// state | meaning: FETCH ir load+pc+4, DECODE reg read, MEMADR addr calc, MEMREAD/MEMWB load,
// MEMWRITE store, EXECUTER/EXECUTEI alu op, ALUWB alu result writeback, BRANCH pc<-target, UNKNOWN illegal op.
module mainfsm #(
  parameter int ILLEGAL_TRAP = 1
) (
  input  logic          clk,
  input  logic          reset,
  mainfsm_if.slave      bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    UNKNOWN  = 4'd10
  } state_t;

  state_t state_q, state_d;

  // Only I (bit 5) and L/S (bit 0) steer sequencing; the rest belong to the ALU decoder.
  logic unused_funct;
  assign unused_funct = ^bus.Funct[4:1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    bus.IRWrite   = 1'b0;
    bus.AdrSrc    = 1'b0;
    bus.ALUSrcA   = 2'b00;
    bus.ALUSrcB   = 2'b00;
    bus.ResultSrc = 2'b00;
    bus.NextPC    = 1'b0;
    bus.RegW      = 1'b0;
    bus.MemW      = 1'b0;
    bus.Branch    = 1'b0;
    bus.ALUOp     = 1'b0;
    bus.Illegal   = 1'b0;
    unique case (state_q)
      FETCH: begin
        bus.IRWrite   = 1'b1;
        bus.ALUSrcA   = 2'b01;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
        bus.NextPC    = 1'b1;
        state_d       = DECODE;
      end
      DECODE: begin
        bus.ALUSrcA   = 2'b01;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
        unique case (bus.Op)
          2'b00:   state_d = bus.Funct[5] ? EXECUTEI : EXECUTER;
          2'b01:   state_d = MEMADR;
          2'b10:   state_d = BRANCH;
          default: state_d = UNKNOWN;
        endcase
      end
      MEMADR: begin
        bus.ALUSrcB = 2'b01;
        state_d     = bus.Funct[0] ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        bus.AdrSrc = 1'b1;
        state_d    = MEMWB;
      end
      MEMWB: begin
        bus.ResultSrc = 2'b01;
        bus.RegW      = 1'b1;
        state_d       = FETCH;
      end
      MEMWRITE: begin
        bus.AdrSrc = 1'b1;
        bus.MemW   = 1'b1;
        state_d    = FETCH;
      end
      EXECUTER: begin
        bus.ALUOp = 1'b1;
        state_d   = ALUWB;
      end
      EXECUTEI: begin
        bus.ALUSrcB = 2'b01;
        bus.ALUOp   = 1'b1;
        state_d     = ALUWB;
      end
      ALUWB: begin
        bus.RegW = 1'b1;
        state_d  = FETCH;
      end
      BRANCH: begin
        bus.ALUSrcA   = 2'b10;
        bus.ALUSrcB   = 2'b01;
        bus.ResultSrc = 2'b10;
        bus.Branch    = 1'b1;
        state_d       = FETCH;
      end
      default: begin
        // Covers UNKNOWN and the unused codes 11-15.
        bus.Illegal = 1'b1;
        state_d     = (ILLEGAL_TRAP != 0) ? state_q : FETCH;
      end
    endcase
  end

  assign bus.State = state_q;

endmodule
